// File: rtl/l1_bus_master.sv
// Per-L1 bus master: takes one coherence transaction from the L1, holds BusReq
// for the whole bus tenure, issues the command, collects snoop/fill results and
// hands a single response back to the L1.
module l1_bus_master #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_W    = 128,
    parameter int unsigned SNOOP_LAT = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              BusReq,
    input  logic              BusGrant,
    output logic              bus_cmd_valid,
    output logic [1:0]        bus_cmd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [LINE_W-1:0] bus_wdata,
    input  logic              bus_shared,
    input  logic              bus_data_valid,
    input  logic [LINE_W-1:0] bus_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [LINE_W-1:0] resp_data,
    output logic              resp_shared,
    output logic              resp_err,
    output logic              err_grant_lost
);

    // One counter serves both the read timeout and the snoop window.
    localparam int unsigned CntMax = (TIMEOUT > SNOOP_LAT) ? TIMEOUT : SNOOP_LAT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] SnoopLast   = CntW'(SNOOP_LAT - 1);
    localparam logic [CntW-1:0] CntSat      = CntW'(CntMax);

    typedef enum logic [2:0] {StIdle, StReq, StCmd, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic              shared_q, shared_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              lost_q, lost_d;
    logic              is_read;

    // BusRd (00) and BusRdX (01) expect fill data; BusUpgr/Flush do not.
    assign is_read = ~cmd_q[1];

    // State register and datapath latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cmd_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            shared_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            shared_q <= shared_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            lost_q   <= lost_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        shared_d = shared_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        lost_d   = lost_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    cmd_d    = req_cmd;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    data_d   = '0;
                    shared_d = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (BusGrant) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (!BusGrant) begin
                    lost_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (!BusGrant) begin
                    lost_d = 1'b1;
                end
                shared_d = shared_q | bus_shared;
                if (is_read) begin
                    if (bus_data_valid) begin
                        data_d  = bus_rdata;
                        state_d = StResp;
                    end else if (cnt_q == TimeoutLast) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else if (cnt_q != CntSat) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else if (cnt_q == SnoopLast) begin
                    state_d = StResp;
                end else if (cnt_q != CntSat) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs come only from state and registers.
    assign req_ready      = (state_q == StIdle);
    assign BusReq         = (state_q == StReq) || (state_q == StCmd) || (state_q == StWait);
    assign bus_cmd_valid  = (state_q == StCmd);
    assign bus_cmd        = cmd_q;
    assign bus_addr       = addr_q;
    assign bus_wdata      = wdata_q;
    assign resp_valid     = (state_q == StResp);
    assign resp_data      = resp_valid ? data_q : '0;
    assign resp_shared    = resp_valid & shared_q;
    assign resp_err       = resp_valid & err_q;
    assign err_grant_lost = lost_q;

endmodule

// File: tb/tb_l1_bus_master.sv
// Directed bench for l1_bus_master: a vector table of single transactions with a
// cycle-level bus model, plus hand-written reset and arbitration sequences.
module tb_l1_bus_master;

    localparam int SnoopLat = 2;
    localparam int Timeout  = 255;

    logic         clk, reset;
    logic         req_valid, req_ready;
    logic [1:0]   req_cmd;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         BusReq, grant_in, tb_grant, use_arb, req1;
    logic         bus_cmd_valid;
    logic [1:0]   bus_cmd;
    logic [31:0]  bus_addr;
    logic [127:0] bus_wdata;
    logic         bus_shared, bus_data_valid;
    logic [127:0] bus_rdata;
    logic         resp_valid, resp_ready;
    logic [127:0] resp_data;
    logic         resp_shared, resp_err, err_grant_lost;
    logic [1:0]   arb_gnt;
    logic         arb_last;

    int n_cmp = 0;
    int n_fail = 0;
    bit gl_exp = 0;

    typedef struct {
        logic [1:0]   cmd;
        logic [31:0]  addr;
        logic [127:0] wdata;
        int           gd;       // REQ cycles before grant is driven
        int           dd;       // data delay after strobe, -1 none
        bit           early;    // junk data pulse on the strobe cycle
        int           sk;       // WAIT cycle with bus_shared, 0 none
        int           hold;     // cycles resp_ready held low in RESP
        bit           drop;     // drop grant on WAIT cycle 1
        logic [127:0] rdata;
        logic [127:0] exp_data;
        bit           exp_sh;
        bit           exp_err;
        int           exp_wait;
    } vec_t;

    vec_t vecs[8];

    l1_bus_master #(
        .ADDR_W   (32),
        .LINE_W   (128),
        .SNOOP_LAT(SnoopLat),
        .TIMEOUT  (Timeout)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .BusReq        (BusReq),
        .BusGrant      (grant_in),
        .bus_cmd_valid (bus_cmd_valid),
        .bus_cmd       (bus_cmd),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_shared    (bus_shared),
        .bus_data_valid(bus_data_valid),
        .bus_rdata     (bus_rdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_shared   (resp_shared),
        .resp_err      (resp_err),
        .err_grant_lost(err_grant_lost)
    );

    assign grant_in = use_arb ? arb_gnt[0] : tb_grant;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-port registered round-robin arbiter: DUT on port 0, a second master on port 1.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_gnt  <= 2'b00;
            arb_last <= 1'b1;
        end else if ((arb_gnt & {req1, BusReq}) != 2'b00) begin
            arb_gnt <= arb_gnt;
        end else if (arb_last && BusReq) begin
            arb_gnt  <= 2'b01;
            arb_last <= 1'b0;
        end else if (req1) begin
            arb_gnt  <= 2'b10;
            arb_last <= 1'b1;
        end else if (BusReq) begin
            arb_gnt  <= 2'b01;
            arb_last <= 1'b0;
        end else begin
            arb_gnt <= 2'b00;
        end
    end

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic [1:0] cmd, input logic [31:0] addr,
                                input logic [127:0] wdata, input int gd, input int dd,
                                input bit early, input int sk, input int hold, input bit drop,
                                input logic [127:0] rdata, input logic [127:0] exp_data,
                                input bit exp_sh, input bit exp_err, input int exp_wait);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.gd = gd; v.dd = dd;
        v.early = early; v.sk = sk; v.hold = hold; v.drop = drop; v.rdata = rdata;
        v.exp_data = exp_data; v.exp_sh = exp_sh; v.exp_err = exp_err; v.exp_wait = exp_wait;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_busreq"}, BusReq, 0);
        check({tag, "_cmd_valid"}, bus_cmd_valid, 0);
        check({tag, "_bus_cmd"}, bus_cmd, 0);
        check({tag, "_bus_addr"}, bus_addr, 0);
        check({tag, "_bus_wdata"}, bus_wdata, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_resp_shared"}, resp_shared, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_grant_lost"}, err_grant_lost, 0);
    endtask

    // One transaction; the loop observes outputs, then drives the bus for that cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int cmd_t, resp_t, strobes;
        bit done;
        cmd_t = -1; resp_t = -1; strobes = 0; done = 0;
        check($sformatf("v%0d_idle_ready", idx), req_ready, 1);
        check($sformatf("v%0d_idle_busreq", idx), BusReq, 0);
        if (v.drop) gl_exp = 1'b1;
        req_valid = 1'b1; req_cmd = v.cmd; req_addr = v.addr; req_wdata = v.wdata;
        resp_ready = (v.hold == 0); tb_grant = 1'b0; bus_shared = 1'b0; bus_data_valid = 1'b0;
        step();
        // Scramble request inputs so only the latched copy can reach the bus.
        req_valid = 1'b0; req_cmd = ~v.cmd; req_addr = ~v.addr; req_wdata = ~v.wdata;
        for (int t = 0; t < 600 && !done; t++) begin
            if (bus_cmd_valid) begin
                strobes++;
                cmd_t = t;
                check($sformatf("v%0d_cmd_time", idx), t, v.gd + 1);
                check($sformatf("v%0d_bus_cmd", idx), bus_cmd, v.cmd);
                check($sformatf("v%0d_bus_addr", idx), bus_addr, v.addr);
                check($sformatf("v%0d_bus_wdata", idx), bus_wdata, v.wdata);
            end
            if (resp_valid && resp_t < 0) resp_t = t;
            if (resp_t < 0) begin
                check($sformatf("v%0d_busreq_hi_t%0d", idx, t), BusReq, 1);
                check($sformatf("v%0d_ready_lo_t%0d", idx, t), req_ready, 0);
            end else if (resp_valid) begin
                check($sformatf("v%0d_resp_data_k%0d", idx, t - resp_t), resp_data, v.exp_data);
                check($sformatf("v%0d_resp_shared_k%0d", idx, t - resp_t), resp_shared, v.exp_sh);
                check($sformatf("v%0d_resp_err_k%0d", idx, t - resp_t), resp_err, v.exp_err);
                check($sformatf("v%0d_resp_busreq_k%0d", idx, t - resp_t), BusReq, 0);
                check($sformatf("v%0d_resp_ready_k%0d", idx, t - resp_t), req_ready, 0);
                resp_ready = ((t - resp_t) >= v.hold);
            end else begin
                done = 1'b1;
                check($sformatf("v%0d_resp_len", idx), t - resp_t, v.hold + 1);
                check($sformatf("v%0d_back_idle", idx), req_ready, 1);
            end
            tb_grant = (t >= v.gd) && !(v.drop && cmd_t >= 0 && t == cmd_t + 1);
            bus_data_valid = (v.early && bus_cmd_valid) ||
                             (cmd_t >= 0 && v.dd > 0 && t == cmd_t + v.dd);
            bus_rdata = (v.early && bus_cmd_valid) ? ~v.rdata : v.rdata;
            bus_shared = (cmd_t >= 0 && v.sk > 0 && t == cmd_t + v.sk);
            if (!done) step();
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL v%0d_timeout: got no completion in 600 cycles, expected one", idx);
        end else begin
            check($sformatf("v%0d_strobes", idx), strobes, 1);
            check($sformatf("v%0d_wait_len", idx), resp_t - cmd_t - 1, v.exp_wait);
            check($sformatf("v%0d_grant_lost", idx), err_grant_lost, gl_exp);
        end
        tb_grant = 1'b0; bus_shared = 1'b0; bus_data_valid = 1'b0; resp_ready = 1'b0;
    endtask

    // Back-to-back BusRd then BusUpgr against the arbiter with a competing master.
    task automatic run_arb();
        int n_acc, n_str, n_resp, f, s, g1_first, oc, rel_t, str_t0, str_t1;
        bit prev_req, acc_now, done;
        n_acc = 0; n_str = 0; n_resp = 0; f = -1; s = -1; g1_first = -1; oc = 0;
        rel_t = -1; str_t0 = -1; str_t1 = -1; prev_req = 0; done = 0;
        use_arb = 1'b1; resp_ready = 1'b1; req1 = 1'b0;
        req_valid = 1'b1; req_cmd = 2'b00; req_addr = 32'h400; req_wdata = '0;
        for (int t = 0; t < 200 && !done; t++) begin
            acc_now = req_ready && req_valid;
            if (prev_req && !BusReq && f < 0 && n_acc >= 1) f = t;
            if (!prev_req && BusReq && f >= 0 && s < 0) s = t;
            prev_req = BusReq;
            if (arb_gnt[1] && g1_first < 0) g1_first = t;
            if (arb_gnt[1]) begin
                oc++;
                if (oc == 4) begin
                    req1 = 1'b0;
                    rel_t = t;
                end
            end
            if (bus_cmd_valid) begin
                n_str++;
                if (n_str == 1) begin
                    str_t0 = t;
                    check("arb_cmd0", bus_cmd, 2'b00);
                    req1 = 1'b1;
                end else begin
                    str_t1 = t;
                    check("arb_cmd1", bus_cmd, 2'b10);
                    check("arb_addr1", bus_addr, 32'h440);
                end
            end
            if (resp_valid) begin
                n_resp++;
                check($sformatf("arb_resp%0d_data", n_resp), resp_data,
                      (n_resp == 1) ? {16{8'h77}} : 128'h0);
                check($sformatf("arb_resp%0d_err", n_resp), resp_err, 0);
            end else if (n_resp == 2) begin
                done = 1'b1;
            end
            bus_data_valid = (n_str == 1 && t == str_t0 + 2);
            bus_rdata = {16{8'h77}};
            if (!done) begin
                step();
                if (acc_now) begin
                    n_acc++;
                    if (n_acc == 1) begin
                        req_cmd = 2'b10;
                        req_addr = 32'h440;
                    end else begin
                        req_valid = 1'b0;
                    end
                end
            end
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL arb_timeout: got %0d responses in 200 cycles, expected 2", n_resp);
        end else begin
            check("arb_strobes", n_str, 2);
            check("arb_busreq_gap", s - f, 2);
            check("arb_other_in_gap", (g1_first >= f) && (g1_first < s), 1);
            check("arb_second_after_release", (rel_t >= 0) && (str_t1 > rel_t), 1);
            check("arb_grant_lost", err_grant_lost, 0);
        end
        use_arb = 1'b0; req1 = 1'b0; bus_data_valid = 1'b0; resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_wdata = '0;
        tb_grant = 1'b0; use_arb = 1'b0; req1 = 1'b0; bus_shared = 1'b0;
        bus_data_valid = 1'b0; bus_rdata = '0; resp_ready = 1'b0;
        #3;
        check_idle_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        vecs[0] = mk(2'b00, 32'h100, '0, 3, 4, 0, 2, 0, 0, {16{8'hA5}}, {16{8'hA5}}, 1, 0, 4);
        vecs[1] = mk(2'b11, 32'h200, {4{32'h1234_5678}}, 0, 1, 0, 0, 0, 0, {16{8'hFF}}, '0,
                     0, 0, SnoopLat);
        vecs[2] = mk(2'b01, 32'h240, {4{32'hDEAD_BEEF}}, 1, -1, 0, 0, 0, 0, {16{8'hEE}}, '0,
                     0, 1, Timeout);
        vecs[3] = mk(2'b00, 32'h280, '0, 0, 1, 1, 1, 0, 0, {16{8'h5A}}, {16{8'h5A}}, 1, 0, 1);
        vecs[4] = mk(2'b10, 32'h2C0, '0, 2, 1, 0, 2, 0, 0, {16{8'hFF}}, '0, 1, 0, SnoopLat);
        vecs[5] = mk(2'b00, 32'h300, '0, 0, 3, 0, 0, 5, 0,
                     128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                     128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 0, 3);
        vecs[6] = mk(2'b01, 32'h340, '0, 0, 2, 0, 0, 0, 1, {16{8'hC3}}, {16{8'hC3}}, 0, 0, 2);
        vecs[7] = mk(2'b00, 32'h380, '0, 1, 1, 0, 0, 0, 0, {16{8'h3C}}, {16{8'h3C}}, 0, 0, 1);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset mid-WAIT: everything clears at once, no response appears.
        req_valid = 1'b1; req_cmd = 2'b00; req_addr = 32'h3C0; req_wdata = '1; tb_grant = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("rw_cmd_strobe", bus_cmd_valid, 1);
        step();
        check("rw_in_wait_busreq", BusReq, 1);
        check("rw_in_wait_no_strobe", bus_cmd_valid, 0);
        #2 reset = 1'b0;
        #1;
        check_idle_outputs("rw");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        tb_grant = 1'b0;
        gl_exp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rw_no_resp_%0d", i), resp_valid, 0);
            check($sformatf("rw_idle_%0d", i), req_ready, 1);
        end
        run_vec(vecs[0], 8);

        run_arb();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_bus_master.md
Name: l1_bus_master

Overview:
- Per-L1 bus-side master that sits directly upstream of the 4-way round-robin bus arbiter; one instance per L1, and its BusReq drives one bit of the arbiter's BusReq[3:0].
- Accepts one coherence transaction (BusRd, BusRdX, BusUpgr, Flush) from the L1 MESI controller and holds BusReq until the transaction completes. The arbiter keeps the grant for as long as BusReq is held.
- Issues the bus command, collects the snoop-shared result and fill data, and returns a single response to the L1.

Parameters:
- ADDR_W, 32, address width
- LINE_W, 128, cache-line data width
- SNOOP_LAT, 2, cycles after the command before BusUpgr/Flush complete (snoop window); must be >=1
- TIMEOUT, 255, maximum wait cycles for read data before an error completion; must be >=1

Ports:
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  L1 request valid
- req_ready  out  1  high only in IDLE
- req_cmd  in  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 Flush
- req_addr  in  ADDR_W  line address
- req_wdata  in  LINE_W  writeback data (Flush only)
- BusReq  out  1  to arbiter request bit
- BusGrant  in  1  from arbiter grant bit
- bus_cmd_valid  out  1  one-cycle command strobe
- bus_cmd  out  2  latched command
- bus_addr  out  ADDR_W  latched address
- bus_wdata  out  LINE_W  latched write data
- bus_shared  in  1  snoop: another cache holds the line
- bus_data_valid  in  1  fill data valid
- bus_rdata  in  LINE_W  fill data
- resp_valid  out  1  response valid
- resp_ready  in  1  L1 accepts response
- resp_data  out  LINE_W  fill data; zero for BusUpgr/Flush/timeout
- resp_shared  out  1  OR of bus_shared over the WAIT window
- resp_err  out  1  timeout completion
- err_grant_lost  out  1  sticky; set if BusGrant falls in CMD or WAIT

Behaviour:
- Reset (asynchronous assert, any state):
  - state goes to IDLE.
  - All outputs go to 0 except req_ready=1.
  - Latched cmd/addr/wdata, data, shared accumulator, counters and err_grant_lost clear.
  - A transaction in flight is abandoned with no response.
- State machine: IDLE -> REQ -> CMD -> WAIT -> RESP -> IDLE. All outputs are registered or decoded from state only; no input-to-output combinational paths.
- IDLE:
  - req_ready=1.
  - On req_valid: latch cmd/addr/wdata, clear shared accumulator and counters, go to REQ.
- REQ:
  - BusReq=1.
  - Stay while BusGrant=0, with no timeout.
  - BusGrant=1 sampled -> CMD. The earliest CMD is 2 cycles after acceptance because the arbiter grant is registered.
- CMD:
  - bus_cmd_valid=1 for exactly one cycle with the latched cmd/addr/wdata, then go to WAIT.
- WAIT:
  - shared_acc |= bus_shared every cycle, including the exit cycle.
  - BusRd/BusRdX, bus_data_valid=1: capture bus_rdata and go to RESP. Data arriving in the same cycle as the command strobe is ignored.
  - BusRd/BusRdX, no data after TIMEOUT cycles in WAIT: set resp_err=1, resp_data=0, go to RESP.
  - BusUpgr/Flush: exit to RESP after exactly SNOOP_LAT cycles; bus_data_valid is ignored.
- BusReq: stays 1 throughout REQ, CMD and WAIT, which keeps the arbiter's grant locked. It is 0 in RESP and IDLE.
- BusReq gap: the minimum BusReq-low gap between back-to-back transactions is 2 cycles (RESP + IDLE). This lets the arbiter release the grant and rotate.
- RESP:
  - resp_valid=1; resp_data/resp_shared/resp_err are held stable until resp_ready=1.
  - Leave on resp_ready: go to IDLE and clear resp_valid.
  - resp_ready already high on entry -> a 1-cycle response.
- Grant loss: BusGrant=0 while in CMD or WAIT sets err_grant_lost (sticky until reset). The transaction continues normally.
- Grant outside a transaction: BusGrant=1 in IDLE or RESP is ignored and flags no error, because the arbiter's registered grant release lags by one cycle.
- Ignored inputs: bus_shared and bus_data_valid are ignored outside WAIT.
- Counters: one counter is shared by the timeout and snoop-latency counts. It is wide enough for max(TIMEOUT, SNOOP_LAT), saturates, and clears on entry to WAIT.

Test Plan:
- BusRd at 0x100, grant 3 cycles after BusReq, data 0xA5..A5 4 cycles after command, bus_shared pulsed on WAIT cycle 2 -> one bus_cmd_valid strobe; resp_valid with data 0xA5..A5, resp_shared=1, resp_err=0; BusReq high from the cycle after acceptance until RESP entry.
- Flush with SNOOP_LAT=2, bus_shared=0, bus_data_valid pulsed in WAIT -> RESP exactly 2 cycles after CMD; resp_data=0, resp_shared=0; bus_wdata equals req_wdata during CMD.
- BusRdX with no data -> resp_err=1 after exactly TIMEOUT WAIT cycles; the next BusRd completes normally.
- Back-to-back BusRd then BusUpgr, resp_ready tied high, with the real arbiter and a second master requesting -> BusReq low for >=2 cycles between transactions; the arbiter grants the other master in that gap; the second transaction completes after the other releases.
- resp_ready held low 5 cycles -> resp_* stable for all 5 cycles; req_ready=0 throughout.
- reset asserted while in WAIT, deasserted 2 cycles later -> outputs immediately 0, req_ready=1; no response; a subsequent BusRd succeeds; BusGrant forced low in WAIT -> err_grant_lost=1 and it stays 1.
